game_next_state: RTL and testbench

Next-state controller for the turn-based game loop. It watches the registered state code from the state register and the player inputs, and computes the 4-bit next-state code that the register loads on every clock. It also owns the phase timer, both players' hit points, the turn hand-off memory and the winner flag that the VGA/HUD logic displays.

---
 rtl/game_next_state_if.sv | 27 ++
 rtl/game_next_state.sv | 129 ++++++++++++
 tb/tb_game_next_state.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_next_state_if.sv
// Signal bundle between the game loop's state register / player inputs and the
// next-state controller. Clk and Reset stay as plain module ports.
interface game_next_state_if #(
  parameter int TIMER_W = 10
);
  logic [3:0]         state;
  logic               frame_tick;
  logic               key_start;
  logic               key_fire;
  logic               hit_p1;
  logic               hit_p2;
  logic [3:0]         next_state;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         p1_hp;
  logic [1:0]         p2_hp;
  logic [1:0]         winner;

  modport master (
    output state, frame_tick, key_start, key_fire, hit_p1, hit_p2,
    input  next_state, timer, p1_hp, p2_hp, winner
  );

  modport slave (
    input  state, frame_tick, key_start, key_fire, hit_p1, hit_p2,
    output next_state, timer, p1_hp, p2_hp, winner
  );
endinterface

// File: rtl/game_next_state.sv
// Next-state logic for the turn-based game loop, plus the phase timer, hit
// points, turn hand-off memory and winner flag shown by the HUD.
module game_next_state #(
  parameter int TIMER_W      = 10,
  parameter int TURN_FRAMES  = 600,
  parameter int SLEEP_FRAMES = 60,
  parameter int DOWN_FRAMES  = 90,
  parameter int MAX_HP       = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  game_next_state_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'h0,
    S_P1TURN  = 4'h1,
    S_P2TURN  = 4'h2,
    S_SLEEP   = 4'h3,
    S_P1DOWN  = 4'h4,
    S_P2DOWN  = 4'h5,
    S_ENDGAME = 4'h6,
    S_MENU    = 4'hF
  } state_t;

  typedef enum logic {
    PL_P1 = 1'b0,
    PL_P2 = 1'b1
  } player_t;

  localparam logic [1:0]         WIN_NONE = 2'b00;
  localparam logic [1:0]         WIN_P1   = 2'b01;
  localparam logic [1:0]         WIN_P2   = 2'b10;
  localparam logic [1:0]         HP_INIT  = 2'(MAX_HP);
  localparam logic [TIMER_W-1:0] T_TURN   = TIMER_W'(TURN_FRAMES);
  localparam logic [TIMER_W-1:0] T_SLEEP  = TIMER_W'(SLEEP_FRAMES);
  localparam logic [TIMER_W-1:0] T_DOWN   = TIMER_W'(DOWN_FRAMES);

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_load;
  logic [1:0]         p1_hp_q;
  logic [1:0]         p2_hp_q;
  logic [1:0]         winner_q;
  player_t            last_q;
  logic               start_prev;
  logic               fire_prev;

  state_t nxt;
  logic   start_pe;
  logic   fire_pe;
  logic   expired;
  logic   changing;

  assign start_pe = bus.key_start & ~start_prev;
  assign fire_pe  = bus.key_fire  & ~fire_prev;
  assign expired  = (timer_q == '0);
  assign changing = (nxt != bus.state);

  // NOTE: nxt gets a value on every path (default item), so no latch is inferred.
  always_comb begin
    case (bus.state)
      S_IDLE:    nxt = S_MENU;
      S_MENU:    nxt = start_pe ? S_P1TURN : S_MENU;
      S_P1TURN:  nxt = bus.hit_p2 ? S_P2DOWN
                     : (fire_pe || expired) ? S_SLEEP : S_P1TURN;
      S_P2TURN:  nxt = bus.hit_p1 ? S_P1DOWN
                     : (fire_pe || expired) ? S_SLEEP : S_P2TURN;
      S_SLEEP:   nxt = !expired ? S_SLEEP
                     : (last_q == PL_P1) ? S_P2TURN : S_P1TURN;
      S_P1DOWN:  nxt = !expired ? S_P1DOWN
                     : (p1_hp_q == 2'd0) ? S_ENDGAME : S_SLEEP;
      S_P2DOWN:  nxt = !expired ? S_P2DOWN
                     : (p2_hp_q == 2'd0) ? S_ENDGAME : S_SLEEP;
      S_ENDGAME: nxt = start_pe ? S_MENU : S_ENDGAME;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (nxt)
      S_P1TURN, S_P2TURN: timer_load = T_TURN;
      S_SLEEP:            timer_load = T_SLEEP;
      S_P1DOWN, S_P2DOWN: timer_load = T_DOWN;
      default:            timer_load = '0;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every update reads the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      timer_q    <= '0;
      p1_hp_q    <= 2'd0;
      p2_hp_q    <= 2'd0;
      winner_q   <= WIN_NONE;
      last_q     <= PL_P2;
      start_prev <= 1'b0;
      fire_prev  <= 1'b0;
    end else begin
      start_prev <= bus.key_start;
      fire_prev  <= bus.key_fire;
      if (changing) begin
        // A state change reloads the timer; a frame tick on this clock is lost.
        timer_q <= timer_load;
        if (bus.state == S_MENU && nxt == S_P1TURN) begin
          p1_hp_q  <= HP_INIT;
          p2_hp_q  <= HP_INIT;
          winner_q <= WIN_NONE;
          last_q   <= PL_P2;
        end
        if (bus.state == S_P1TURN) last_q <= PL_P1;
        if (bus.state == S_P2TURN) last_q <= PL_P2;
        if (nxt == S_P1DOWN && p1_hp_q != 2'd0) p1_hp_q <= p1_hp_q - 2'd1;
        if (nxt == S_P2DOWN && p2_hp_q != 2'd0) p2_hp_q <= p2_hp_q - 2'd1;
        if (nxt == S_ENDGAME && bus.state == S_P2DOWN) winner_q <= WIN_P1;
        if (nxt == S_ENDGAME && bus.state == S_P1DOWN) winner_q <= WIN_P2;
      end else if (bus.frame_tick && !expired) begin
        timer_q <= timer_q - TIMER_W'(1);
      end
    end
  end

  assign bus.next_state = nxt;
  assign bus.timer      = timer_q;
  assign bus.p1_hp      = p1_hp_q;
  assign bus.p2_hp      = p2_hp_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_game_next_state.sv
// Self-checking bench for game_next_state: reset-time vector table, directed
// game sequences, then randomized play against a rule-level reference model.
module tb_game_next_state;

  localparam int TW      = 10;
  localparam int F_TURN  = 4;
  localparam int F_SLEEP = 2;
  localparam int F_DOWN  = 3;
  localparam int HP      = 3;

  localparam int ST_IDLE = 0, ST_P1T = 1, ST_P2T = 2, ST_SLEEP = 3;
  localparam int ST_P1D  = 4, ST_P2D = 5, ST_END = 6, ST_MENU = 15;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  game_next_state_if #(.TIMER_W(TW)) bus ();

  game_next_state #(
    .TIMER_W(TW), .TURN_FRAMES(F_TURN), .SLEEP_FRAMES(F_SLEEP),
    .DOWN_FRAMES(F_DOWN), .MAX_HP(HP)
  ) u_dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the state register plus the controller's hidden state.
  int m_state, m_timer, m_p1, m_p2, m_win, m_last, m_nxt;
  bit m_sprev, m_fprev;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = ST_IDLE; m_timer = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
    m_last = 2; m_sprev = 0; m_fprev = 0;
  endtask

  function automatic int dest_frames(input int s);
    if (s == ST_P1T || s == ST_P2T) return F_TURN;
    if (s == ST_SLEEP)              return F_SLEEP;
    if (s == ST_P1D || s == ST_P2D) return F_DOWN;
    return 0;
  endfunction

  function automatic int model_next(input int st, input bit ks, input bit kf,
                                    input bit h1, input bit h2);
    bit sp, fp, ex;
    sp = ks && !m_sprev;
    fp = kf && !m_fprev;
    ex = (m_timer == 0);
    case (st)
      ST_IDLE:  return ST_MENU;
      ST_MENU:  return sp ? ST_P1T : ST_MENU;
      ST_P1T:   return h2 ? ST_P2D : ((fp || ex) ? ST_SLEEP : ST_P1T);
      ST_P2T:   return h1 ? ST_P1D : ((fp || ex) ? ST_SLEEP : ST_P2T);
      ST_SLEEP: return !ex ? ST_SLEEP : ((m_last == 1) ? ST_P2T : ST_P1T);
      ST_P1D:   return !ex ? ST_P1D : ((m_p1 == 0) ? ST_END : ST_SLEEP);
      ST_P2D:   return !ex ? ST_P2D : ((m_p2 == 0) ? ST_END : ST_SLEEP);
      ST_END:   return sp ? ST_MENU : ST_END;
      default:  return ST_IDLE;
    endcase
  endfunction

  task automatic model_clock(input int st, input bit tk, input bit ks, input bit kf);
    if (m_nxt != st) begin
      m_timer = dest_frames(m_nxt);
      if (st == ST_MENU && m_nxt == ST_P1T) begin
        m_p1 = HP; m_p2 = HP; m_win = 0; m_last = 2;
      end
      if (st == ST_P1T) m_last = 1;
      if (st == ST_P2T) m_last = 2;
      if (m_nxt == ST_P1D && m_p1 > 0) m_p1--;
      if (m_nxt == ST_P2D && m_p2 > 0) m_p2--;
      if (m_nxt == ST_END && st == ST_P2D) m_win = 1;
      if (m_nxt == ST_END && st == ST_P1D) m_win = 2;
    end else if (tk && m_timer > 0) begin
      m_timer--;
    end
    m_sprev = ks;
    m_fprev = kf;
    m_state = m_nxt;
  endtask

  // One clock: drive just after a rising edge, check next_state at the falling
  // edge, then check registered outputs 1 time unit after the next rising edge.
  task automatic step_st(input int st, input bit tk, input bit ks, input bit kf,
                         input bit h1, input bit h2);
    bus.state = 4'(st); bus.frame_tick = tk; bus.key_start = ks;
    bus.key_fire = kf; bus.hit_p1 = h1; bus.hit_p2 = h2;
    @(negedge Clk);
    m_nxt = model_next(st, ks, kf, h1, h2);
    check("next_state", int'(bus.next_state), m_nxt);
    @(posedge Clk);
    model_clock(st, tk, ks, kf);
    #1;
    check("timer", int'(bus.timer), m_timer);
    check("p1_hp", int'(bus.p1_hp), m_p1);
    check("p2_hp", int'(bus.p2_hp), m_p2);
    check("winner", int'(bus.winner), m_win);
  endtask

  task automatic step(input bit tk, input bit ks, input bit kf, input bit h1, input bit h2);
    step_st(m_state, tk, ks, kf, h1, h2);
  endtask

  // Tick until the phase timer runs out, then one more clock for the transition.
  task automatic expire();
    for (int k = 0; k < 64 && m_timer != 0; k++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic fire_press();
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input bit ks_held);
    #2;
    Reset = 1'b1;
    model_reset();
    bus.state = 4'(ST_IDLE); bus.frame_tick = 1'b0; bus.key_start = ks_held;
    bus.key_fire = 1'b0; bus.hit_p1 = 1'b0; bus.hit_p2 = 1'b0;
    #1;
    check("rst timer", int'(bus.timer), 0);
    check("rst p1_hp", int'(bus.p1_hp), 0);
    check("rst p2_hp", int'(bus.p2_hp), 0);
    check("rst winner", int'(bus.winner), 0);
    check("rst next_state", int'(bus.next_state), ST_MENU);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] state;
    bit         ks, kf, h1, h2;
    logic [3:0] exp_next;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Held in reset: timer=0 (expired), hp=0/0, last=P2, key history cleared.
    vecs.push_back('{4'h0, 0, 0, 0, 0, 4'hF});
    vecs.push_back('{4'hF, 0, 0, 0, 0, 4'hF});
    vecs.push_back('{4'hF, 1, 0, 0, 0, 4'h1});
    vecs.push_back('{4'h1, 0, 0, 0, 0, 4'h3});
    vecs.push_back('{4'h1, 0, 1, 0, 1, 4'h5});
    vecs.push_back('{4'h1, 0, 0, 1, 0, 4'h3});
    vecs.push_back('{4'h2, 0, 0, 1, 0, 4'h4});
    vecs.push_back('{4'h2, 0, 0, 0, 1, 4'h3});
    vecs.push_back('{4'h3, 0, 0, 0, 0, 4'h1});
    vecs.push_back('{4'h4, 0, 0, 1, 1, 4'h6});
    vecs.push_back('{4'h5, 0, 0, 0, 0, 4'h6});
    vecs.push_back('{4'h6, 0, 0, 0, 0, 4'h6});
    vecs.push_back('{4'h6, 1, 0, 0, 0, 4'hF});
    vecs.push_back('{4'h7, 1, 1, 1, 1, 4'h0});
    vecs.push_back('{4'hE, 0, 0, 0, 0, 4'h0});
    vecs.push_back('{4'h9, 0, 0, 0, 0, 4'h0});

    model_reset();
    bus.state = 4'h0; bus.frame_tick = 1'b0; bus.key_start = 1'b0;
    bus.key_fire = 1'b0; bus.hit_p1 = 1'b0; bus.hit_p2 = 1'b0;
    #7;
    check("reset timer", int'(bus.timer), 0);
    check("reset p1_hp", int'(bus.p1_hp), 0);
    check("reset p2_hp", int'(bus.p2_hp), 0);
    check("reset winner", int'(bus.winner), 0);
    foreach (vecs[i]) begin
      bus.state = vecs[i].state; bus.key_start = vecs[i].ks; bus.key_fire = vecs[i].kf;
      bus.hit_p1 = vecs[i].h1; bus.hit_p2 = vecs[i].h2;
      #1;
      check($sformatf("vec%0d next_state", i), int'(bus.next_state), int'(vecs[i].exp_next));
    end

    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Basic game flow with explicit expectations.
    step(0, 0, 0, 0, 0);
    check("menu timer", int'(bus.timer), 0);
    check("menu winner", int'(bus.winner), 0);
    step(0, 1, 0, 0, 0);
    check("start p1_hp", int'(bus.p1_hp), 3);
    check("start p2_hp", int'(bus.p2_hp), 3);
    check("start timer", int'(bus.timer), F_TURN);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < F_TURN; k++) step(1, 0, 0, 0, 0);
    check("turn expired timer", int'(bus.timer), 0);
    step(0, 0, 0, 0, 0);
    check("sleep timer", int'(bus.timer), F_SLEEP);
    expire();
    check("p2turn timer", int'(bus.timer), F_TURN);
    fire_press();
    expire();
    check("back to p1turn timer", int'(bus.timer), F_TURN);

    // Hit and fire together: the hit wins.
    step(0, 0, 1, 0, 1);
    check("hit1 p2_hp", int'(bus.p2_hp), 2);
    check("hit1 timer", int'(bus.timer), F_DOWN);
    step(0, 0, 0, 1, 1);
    check("down ignores hits", int'(bus.p2_hp), 2);
    expire();
    check("after down sleep timer", int'(bus.timer), F_SLEEP);
    expire();

    for (int r = 2; r <= 3; r++) begin
      fire_press();
      expire();
      step(0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0);
      expire();
      if (r == 2) expire();
    end
    check("endgame winner", int'(bus.winner), 1);
    check("endgame p2_hp", int'(bus.p2_hp), 0);
    check("endgame p1_hp", int'(bus.p1_hp), 3);
    check("endgame timer", int'(bus.timer), 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("restart p1_hp", int'(bus.p1_hp), 3);
    check("restart p2_hp", int'(bus.p2_hp), 3);
    check("restart winner", int'(bus.winner), 0);

    // Reset in the middle of P2's turn.
    step(0, 0, 0, 0, 0);
    expire();
    expire();
    step(1, 0, 0, 0, 0);
    check("p2turn running timer", int'(bus.timer), F_TURN - 1);
    do_reset(1'b0);
    step(0, 0, 0, 0, 0);

    // Start held through reset release counts as one press.
    do_reset(1'b1);
    step_st(ST_MENU, 0, 1, 0, 0, 0);
    check("held start p1_hp", int'(bus.p1_hp), 3);
    step(0, 1, 0, 0, 0);

    // Randomized play with occasional forced state codes and resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        int st;
        st = ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, 15)) : m_state;
        step_st(st,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
